serial_unary_reducer: RTL and testbench

- Receive side of a bit-serial operand link.
- Accepts an N-bit operand as N/W beats of W bits, LSB beat first, under valid/ready.
- Reassembles the word and produces its unary AND, OR and XOR reductions, then presents them on a valid/ready result port.
- Sequential counterpart of the team's combinational unary reduction units, for narrow or serialised datapaths.

---
 rtl/serial_unary_reducer_pkg.sv | 32 +++
 rtl/serial_unary_reducer_beat_reduce.sv | 23 ++
 rtl/serial_unary_reducer.sv | 181 ++++++++++++++++++
 tb/tb_serial_unary_reducer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_unary_reducer_pkg.sv
// -----------------------------------------------------------------------------
// serial_unary_reducer_pkg
// Shared types and helpers for the serial unary reducer:
//   state_t          - two-state control FSM (COLLECT beats / HOLD result)
//   beats(n, w)      - number of W-bit beats per N-bit operand
//   cnt_w(n, w)      - beat counter width, never less than one bit
//   AND/OR/XOR_INIT  - identity values the reduction accumulators start from
// -----------------------------------------------------------------------------
package serial_unary_reducer_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    localparam logic AND_INIT = 1'b1;
    localparam logic OR_INIT  = 1'b0;
    localparam logic XOR_INIT = 1'b0;

    function automatic int beats(input int n, input int w);
        return n / w;
    endfunction

    // A single-beat word still needs a one-bit counter so the ports and
    // compare logic have a legal width.
    function automatic int cnt_w(input int n, input int w);
        int c;
        c = $clog2(n / w);
        return (c < 1) ? 1 : c;
    endfunction

endpackage

// File: rtl/serial_unary_reducer_beat_reduce.sv
// -----------------------------------------------------------------------------
// unary_beat_reduce
// Combinational AND/OR/XOR reduction of one input beat.
// Ports:
//   s_data  [W-1:0]  beat payload
//   red_and          &s_data
//   red_or           |s_data
//   red_xor          ^s_data
// -----------------------------------------------------------------------------
module unary_beat_reduce #(
    parameter int W = 1
) (
    input  logic [W-1:0] s_data,
    output logic         red_and,
    output logic         red_or,
    output logic         red_xor
);

    assign red_and = &s_data;
    assign red_or  = |s_data;
    assign red_xor = ^s_data;

endmodule

// File: rtl/serial_unary_reducer.sv
// -----------------------------------------------------------------------------
// serial_unary_reducer
// Receives an N-bit operand as N/W beats of W bits (LSB beat first) under
// valid/ready, reassembles it and presents the word with its AND, OR and XOR
// reductions on a valid/ready result port. Beats and results never overlap:
// while a result is held, s_ready is low.
//
// Optional feature (macro SERIAL_UNARY_REDUCER_LAST_CHECK_EN):
//   adds s_last (beat framing marker) and m_err (sticky framing error for the
//   presented word). Framing is always by beat count; s_last is only checked.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   s_valid/s_ready   input beat handshake
//   s_data  [W-1:0]   beat payload, beat k carries operand bits [k*W +: W]
//   m_valid/m_ready   result handshake
//   m_word  [N-1:0]   reassembled operand
//   m_and/m_or/m_xor  reductions of the operand
//   s_last, m_err     only with SERIAL_UNARY_REDUCER_LAST_CHECK_EN
// -----------------------------------------------------------------------------
module serial_unary_reducer
    import serial_unary_reducer_pkg::*;
#(
    parameter int N = 8,
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [W-1:0] s_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [N-1:0] m_word,
    output logic         m_and,
    output logic         m_or,
    output logic         m_xor
`ifdef SERIAL_UNARY_REDUCER_LAST_CHECK_EN
    ,
    input  logic         s_last,
    output logic         m_err
`endif
);

    localparam int BEATS = beats(N, W);
    localparam int CW    = cnt_w(N, W);
    localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);

    generate
        if ((W < 1) || (W > N) || ((N % W) != 0)) begin : g_bad_cfg
            $error("serial_unary_reducer: need 1 <= W <= N and N %% W == 0");
        end
    endgenerate

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          m_valid_q, m_valid_d;
    logic [N-1:0]  word_q, word_d;
    logic          and_q, and_d;
    logic          or_q, or_d;
    logic          xor_q, xor_d;

    logic          beat_and, beat_or, beat_xor;
    logic          accept;
    logic          is_last;
    logic [BEATS-1:0] beat_sel;

    unary_beat_reduce #(.W(W)) u_beat_reduce (
        .s_data  (s_data),
        .red_and (beat_and),
        .red_or  (beat_or),
        .red_xor (beat_xor)
    );

    // One-hot select of the word slice the current beat lands in.
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat_sel
        assign beat_sel[gi] = (cnt_q == CW'(gi));
    end

    assign s_ready = (state_q == COLLECT);
    assign accept  = s_valid && (state_q == COLLECT);
    assign is_last = (cnt_q == LAST_CNT);

`ifdef SERIAL_UNARY_REDUCER_LAST_CHECK_EN
    logic err_q, err_d;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        m_valid_d = m_valid_q;
        word_d    = word_q;
        and_d     = and_q;
        or_d      = or_q;
        xor_d     = xor_q;
`ifdef SERIAL_UNARY_REDUCER_LAST_CHECK_EN
        err_d     = err_q;
`endif
        case (state_q)
            COLLECT: begin
                if (accept) begin
                    for (int i = 0; i < BEATS; i++) begin
                        if (beat_sel[i]) begin
                            word_d[i*W +: W] = s_data;
                        end
                    end
                    and_d = and_q & beat_and;
                    or_d  = or_q  | beat_or;
                    xor_d = xor_q ^ beat_xor;
`ifdef SERIAL_UNARY_REDUCER_LAST_CHECK_EN
                    // Marker must agree with the count-based framing on
                    // every beat, early or missing markers both count.
                    if (s_last != is_last) begin
                        err_d = 1'b1;
                    end
`endif
                    if (is_last) begin
                        cnt_d     = '0;
                        state_d   = HOLD;
                        m_valid_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            HOLD: begin
                if (m_ready) begin
                    state_d   = COLLECT;
                    m_valid_d = 1'b0;
                    // Word register is left alone; it is overwritten beat
                    // by beat as the next operand arrives.
                    and_d     = AND_INIT;
                    or_d      = OR_INIT;
                    xor_d     = XOR_INIT;
`ifdef SERIAL_UNARY_REDUCER_LAST_CHECK_EN
                    err_d     = 1'b0;
`endif
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= COLLECT;
            cnt_q     <= '0;
            m_valid_q <= 1'b0;
            word_q    <= '0;
            and_q     <= AND_INIT;
            or_q      <= OR_INIT;
            xor_q     <= XOR_INIT;
`ifdef SERIAL_UNARY_REDUCER_LAST_CHECK_EN
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            m_valid_q <= m_valid_d;
            word_q    <= word_d;
            and_q     <= and_d;
            or_q      <= or_d;
            xor_q     <= xor_d;
`ifdef SERIAL_UNARY_REDUCER_LAST_CHECK_EN
            err_q     <= err_d;
`endif
        end
    end

    assign m_valid = m_valid_q;
    assign m_word  = word_q;
    assign m_and   = and_q;
    assign m_or    = or_q;
    assign m_xor   = xor_q;
`ifdef SERIAL_UNARY_REDUCER_LAST_CHECK_EN
    assign m_err   = err_q;
`endif

endmodule

// File: tb/tb_serial_unary_reducer.sv
// -----------------------------------------------------------------------------
// tb_serial_unary_reducer
// Drives an N=8/W=2 instance with directed and random words (random gaps and
// result back-pressure) and an N=8/W=8 instance with back-to-back words.
// Expected results come from a queue of accepted beats reassembled with plain
// arithmetic, reductions taken on the reassembled word.
// Macro SERIAL_UNARY_REDUCER_LAST_CHECK_EN adds s_last/m_err checks.
// -----------------------------------------------------------------------------
module tb_serial_unary_reducer;

    localparam int N     = 8;
    localparam int W     = 2;
    localparam int BEATS = N / W;

    logic         clk = 1'b0;
    logic         rst;

    logic         s_valid, s_ready, m_valid, m_ready;
    logic [W-1:0] s_data;
    logic [N-1:0] m_word;
    logic         m_and, m_or, m_xor;

    logic         s_valid8, s_ready8, m_valid8, m_ready8;
    logic [N-1:0] s_data8, m_word8;
    logic         m_and8, m_or8, m_xor8;

`ifdef SERIAL_UNARY_REDUCER_LAST_CHECK_EN
    logic s_last, m_err, s_last8, m_err8;
`endif

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] model_q[$];

    always #5 clk = ~clk;

    serial_unary_reducer #(.N(N), .W(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_word  (m_word),
        .m_and   (m_and),
        .m_or    (m_or),
        .m_xor   (m_xor)
`ifdef SERIAL_UNARY_REDUCER_LAST_CHECK_EN
        ,
        .s_last  (s_last),
        .m_err   (m_err)
`endif
    );

    serial_unary_reducer #(.N(N), .W(N)) dut8 (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid8),
        .s_ready (s_ready8),
        .s_data  (s_data8),
        .m_valid (m_valid8),
        .m_ready (m_ready8),
        .m_word  (m_word8),
        .m_and   (m_and8),
        .m_or    (m_or8),
        .m_xor   (m_xor8)
`ifdef SERIAL_UNARY_REDUCER_LAST_CHECK_EN
        ,
        .s_last  (s_last8),
        .m_err   (m_err8)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Sends one word beat by beat, checks the result, optionally holds it
    // under back-pressure for 'hold' cycles, then completes the handshake.
    // 'early' is the beat index that additionally carries s_last (-1: none).
    task automatic send_word(input logic [N-1:0] w, input int gap, input int hold, input int early);
        logic [N-1:0] exp_w;
        logic [W-1:0] b;
        logic         exp_err;
        int           n;
        model_q.delete();
        exp_err = (early >= 0) && (early != BEATS - 1);
        for (int k = 0; k < BEATS; k++) begin
            b = W'(w >> (k * W));
            for (int g = 0; g < gap; g++) begin
                s_valid = 1'b0;
                s_data  = W'($urandom);
                @(negedge clk);
                check("gap_s_ready", 32'(s_ready), 32'd1);
                check("gap_m_valid", 32'(m_valid), 32'd0);
            end
            s_valid = 1'b1;
            s_data  = b;
`ifdef SERIAL_UNARY_REDUCER_LAST_CHECK_EN
            s_last  = (k == BEATS - 1) || (k == early);
`endif
            n = 0;
            while (!s_ready && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("beat_s_ready", 32'(s_ready), 32'd1);
            @(negedge clk);
            model_q.push_back(b);
            s_valid = 1'b0;
`ifdef SERIAL_UNARY_REDUCER_LAST_CHECK_EN
            s_last  = 1'b0;
`endif
            if (k != BEATS - 1) begin
                check("mid_m_valid", 32'(m_valid), 32'd0);
            end
        end
        exp_w = '0;
        foreach (model_q[i]) exp_w |= N'(model_q[i]) << (i * W);
        check("res_m_valid", 32'(m_valid), 32'd1);
        check("res_s_ready", 32'(s_ready), 32'd0);
        check("res_m_word",  32'(m_word),  32'(exp_w));
        check("res_m_and",   32'(m_and),   32'(&exp_w));
        check("res_m_or",    32'(m_or),    32'(|exp_w));
        check("res_m_xor",   32'(m_xor),   32'(^exp_w));
`ifdef SERIAL_UNARY_REDUCER_LAST_CHECK_EN
        check("res_m_err",   32'(m_err),   32'(exp_err));
`else
        exp_err = 1'b0;
`endif
        m_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            s_valid = 1'b1;
            s_data  = W'($urandom);
            @(negedge clk);
            check("hold_s_ready", 32'(s_ready), 32'd0);
            check("hold_m_valid", 32'(m_valid), 32'd1);
            check("hold_m_word",  32'(m_word),  32'(exp_w));
            check("hold_red",     {29'd0, m_and, m_or, m_xor}, {29'd0, &exp_w, |exp_w, ^exp_w});
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        check("done_m_valid", 32'(m_valid), 32'd0);
        check("done_s_ready", 32'(s_ready), 32'd1);
        check("done_m_word",  32'(m_word),  32'(exp_w));
        check("done_acc_init", {29'd0, m_and, m_or, m_xor}, 32'b100);
    endtask

    initial begin
        rst      = 1'b1;
        s_valid  = 1'b0;
        s_data   = '0;
        m_ready  = 1'b0;
        s_valid8 = 1'b0;
        s_data8  = '0;
        m_ready8 = 1'b0;
`ifdef SERIAL_UNARY_REDUCER_LAST_CHECK_EN
        s_last   = 1'b0;
        s_last8  = 1'b1;
`endif
        repeat (3) @(negedge clk);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd1);
        check("rst_m_word",  32'(m_word),  32'd0);
        check("rst_red",     {29'd0, m_and, m_or, m_xor}, 32'b100);
        rst = 1'b0;

        // Directed words: continuous, gapped, back-pressured.
        send_word(8'hFF, 0, 0, -1);
        send_word(8'h01, 2, 0, -1);
        send_word(8'h00, 0, 5, -1);

        // Partial word discarded by reset.
        s_valid = 1'b1;
        s_data  = 2'b00;
        @(negedge clk);
        @(negedge clk);
        s_valid = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        check("rst2_m_valid", 32'(m_valid), 32'd0);
        check("rst2_m_word",  32'(m_word),  32'd0);
        check("rst2_red",     {29'd0, m_and, m_or, m_xor}, 32'b100);
        send_word(8'h0F, 0, 0, -1);

        // Random words with random gaps and back-pressure.
        for (int r = 0; r < 12; r++) begin
            send_word(N'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), -1);
        end

`ifdef SERIAL_UNARY_REDUCER_LAST_CHECK_EN
        send_word(8'h55, 0, 0, 1);
        send_word(8'h5A, 0, 0, -1);
`endif

        // Single-beat instance: back-to-back words with m_ready held high.
        m_ready8 = 1'b1;
        s_valid8 = 1'b1;
        s_data8  = 8'hAA;
        @(negedge clk);
        check("w8_aa_m_valid", 32'(m_valid8), 32'd1);
        check("w8_aa_s_ready", 32'(s_ready8), 32'd0);
        check("w8_aa_m_word",  32'(m_word8),  32'hAA);
        check("w8_aa_red",     {29'd0, m_and8, m_or8, m_xor8}, 32'b010);
        s_data8  = 8'h7F;
        @(negedge clk);
        check("w8_mid_m_valid", 32'(m_valid8), 32'd0);
        check("w8_mid_s_ready", 32'(s_ready8), 32'd1);
        @(negedge clk);
        s_valid8 = 1'b0;
        check("w8_7f_m_valid", 32'(m_valid8), 32'd1);
        check("w8_7f_s_ready", 32'(s_ready8), 32'd0);
        check("w8_7f_m_word",  32'(m_word8),  32'h7F);
        check("w8_7f_red",     {29'd0, m_and8, m_or8, m_xor8}, 32'b011);
`ifdef SERIAL_UNARY_REDUCER_LAST_CHECK_EN
        check("w8_7f_m_err",   32'(m_err8),   32'd0);
`endif
        @(negedge clk);
        check("w8_end_m_valid", 32'(m_valid8), 32'd0);
        check("w8_end_s_ready", 32'(s_ready8), 32'd1);
        m_ready8 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
